sram_bridge: RTL and testbench

- Parametrised successor to the CPLD SRAM glue.
- Arbitrates one external SRAM between an AVR-side port and a SNES-side port.
- AVR side: address loaded serially through a shift register, optionally stepped by an increment strobe; reads and writes run through a timed access FSM with configurable wait states.
- SNES side: combinational read-only passthrough when snes_mode is active.

---
 rtl/sram_bridge_pkg.sv | 29 ++
 rtl/sram_addr_sreg.sv | 52 +++++
 rtl/sram_bridge.sv | 177 +++++++++++++++++
 tb/tb_sram_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared FSM encoding, default widths and wait-state bounds for sram_bridge.
// Revision: 1.0
`default_nettype none

package sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_MIN   = 1;
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = 4;

  // Index of the final STROBE cycle; out-of-range wait counts are clamped into 1..15.
  function automatic logic [WAIT_CNT_W-1:0] last_wait_idx(input int waits);
    int w;
    w = (waits < WAIT_MIN) ? WAIT_MIN : ((waits > WAIT_MAX) ? WAIT_MAX : waits);
    return WAIT_CNT_W'(w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_addr_sreg.sv
// sram_addr_sreg: serial-load AVR address register with wrapping increment and busy lockout.
// Revision: 1.0
`default_nettype none

module sram_addr_sreg
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              autoinc_i,
  input  logic              sreg_en_n_i,
  input  logic              sreg_si_i,
  input  logic              counter_n_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // autoinc only fires while busy, so it never stacks with a counter_n strobe.
  always_comb begin
    addr_d = addr_q;
    if (autoinc_i) begin
      addr_d = addr_inc;
    end else if (!busy_i) begin
      if (!sreg_en_n_i) begin
        addr_d = {addr_q[ADDR_W-2:0], sreg_si_i};
      end else if (!counter_n_i) begin
        addr_d = addr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/sram_bridge.sv
// sram_bridge: arbitrates one SRAM between a timed AVR access port and a SNES read passthrough.
// Optional macro SRAM_BRIDGE_AUTOINC_EN: step the AVR address in HOLD of every access. Revision: 1.0
`default_nettype none

module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snes_mode,
  input  logic              sreg_en_n,
  input  logic              sreg_si,
  input  logic              counter_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_err,
  output logic [ADDR_W-1:0] addr_q,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic [DATA_W-1:0] snes_data,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ce_n
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = last_wait_idx(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    req_err_q, req_err_d;
  logic                    autoinc;

`ifdef SRAM_BRIDGE_AUTOINC_EN
  assign autoinc = (state_q == HOLD);
`else
  assign autoinc = 1'b0;
`endif

  sram_addr_sreg #(
    .ADDR_W (ADDR_W)
  ) u_addr_sreg (
    .clk         (clk),
    .reset       (reset),
    .busy_i      (busy),
    .autoinc_i   (autoinc),
    .sreg_en_n_i (sreg_en_n),
    .sreg_si_i   (sreg_si),
    .counter_n_i (counter_n),
    .addr_o      (addr_q)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    is_wr_d    = is_wr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    req_err_d  = req_err_q;

    unique case (state_q)
      IDLE: begin
        if (!snes_mode) begin
          if (rd_req && wr_req) begin
            req_err_d = 1'b1;
          end else if (rd_req) begin
            is_wr_d = 1'b0;
            state_d = SETUP;
          end else if (wr_req) begin
            is_wr_d = 1'b1;
            wdata_d = avr_wdata;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        wait_cnt_d = '0;
        state_d    = STROBE;
      end
      STROBE: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = HOLD;
          if (!is_wr_q) begin
            rdata_d = sram_data_i;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_wr_q    <= is_wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      req_err_q  <= req_err_d;
    end
  end

  // Pad controls decode straight from state; SNES passthrough is blanked while reset is held.
  always_comb begin
    sram_addr    = addr_q;
    snes_data    = '0;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b0;
    rd_valid     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (snes_mode && !reset) begin
          sram_addr = snes_addr;
          sram_ce_n = 1'b0;
          sram_oe_n = 1'b0;
          snes_data = sram_data_i;
        end
      end
      SETUP: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = is_wr_q;
      end
      STROBE: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = is_wr_q;
        sram_oe_n    = is_wr_q;
        sram_we_n    = !is_wr_q;
      end
      HOLD: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = is_wr_q;
        rd_valid     = !is_wr_q;
      end
      default: begin
        sram_ce_n = 1'b1;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign avr_rdata   = rdata_q;
  assign req_err     = req_err_q;
  assign sram_data_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed self-checking bench for sram_bridge with WAIT_STATES=2 and a small SRAM model.
// Revision: 1.0
`default_nettype none

module tb_sram_bridge;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              snes_mode;
  logic              sreg_en_n;
  logic              sreg_si;
  logic              counter_n;
  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] avr_wdata;
  logic [DATA_W-1:0] avr_rdata;
  logic              rd_valid;
  logic              busy;
  logic              req_err;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] snes_addr;
  logic [DATA_W-1:0] snes_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_i;
  logic [DATA_W-1:0] sram_data_o;
  logic              sram_data_oe;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ce_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snes_mode    (snes_mode),
    .sreg_en_n    (sreg_en_n),
    .sreg_si      (sreg_si),
    .counter_n    (counter_n),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .avr_wdata    (avr_wdata),
    .avr_rdata    (avr_rdata),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .req_err      (req_err),
    .addr_q       (addr_q),
    .snes_addr    (snes_addr),
    .snes_data    (snes_data),
    .sram_addr    (sram_addr),
    .sram_data_i  (sram_data_i),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_ce_n    (sram_ce_n)
  );

  // Behavioural SRAM indexed by the low address byte.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_data_o;
  end
  assign sram_data_i = sram_oe_n ? 8'h00 : mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_addr(input logic [ADDR_W-1:0] a);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      sreg_en_n = 1'b0;
      sreg_si   = a[i];
      tick();
    end
    sreg_en_n = 1'b1;
    sreg_si   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int we_low;
    int oe_hi;
    int lat;
    int n;
    logic [ADDR_W-1:0] exp_auto;
    logic [ADDR_W-1:0] exp_lock;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h45] = 8'h3C;

    reset = 1'b1; snes_mode = 1'b0; sreg_en_n = 1'b1; sreg_si = 1'b0;
    counter_n = 1'b1; rd_req = 1'b0; wr_req = 1'b0; avr_wdata = '0; snes_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_addr", 32'(addr_q), 32'h0);
    check("rst_rdata", 32'(avr_rdata), 32'h0);
    check("rst_strobes", {28'd0, rd_valid, busy, req_err, sram_data_oe}, 32'h0);
    check("rst_pads_n", {29'd0, sram_oe_n, sram_we_n, sram_ce_n}, 32'h7);

    shift_addr(21'h1ABCDE);
    check("shift_addr", 32'(addr_q), 32'h1ABCDE);
    check("shift_sram_addr", 32'(sram_addr), 32'h1ABCDE);
    check("avr_snes_data", 32'(snes_data), 32'h0);

    shift_addr(21'h1FFFFF);
    counter_n = 1'b0; tick(); counter_n = 1'b1;
    check("wrap", 32'(addr_q), 32'h0);

    // Shift beats increment: 0 -> 1 -> 3 (increment alone would give 2).
    counter_n = 1'b0; sreg_en_n = 1'b0; sreg_si = 1'b1;
    tick(); tick();
    counter_n = 1'b1; sreg_en_n = 1'b1; sreg_si = 1'b0;
    check("shift_wins", 32'(addr_q), 32'h3);

    shift_addr(21'h000010);
    wr_req = 1'b1; avr_wdata = 8'hA5; tick(); wr_req = 1'b0; avr_wdata = 8'h00;
    check("wr_busy", {31'd0, busy}, 32'd1);
    we_low = 0; oe_hi = 0;
    for (int k = 0; k < 6; k++) begin
      if (!sram_we_n) we_low++;
      if (sram_data_oe) oe_hi++;
      if (k == 1) check("wr_data", 32'(sram_data_o), 32'hA5);
      tick();
    end
    check("wr_we_cycles", 32'(we_low), 32'd2);
    check("wr_oe_cycles", 32'(oe_hi), 32'd4);
    check("wr_mem", 32'(mem[8'h10]), 32'hA5);

    shift_addr(21'h000010);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_data", 32'(avr_rdata), 32'hA5);
    tick();
    check("rd_valid_pulse", {30'd0, rd_valid, busy}, 32'h0);

    rd_req = 1'b1; wr_req = 1'b1; tick(); rd_req = 1'b0; wr_req = 1'b0;
    check("coll_err", {31'd0, req_err}, 32'd1);
    check("coll_idle", {29'd0, busy, sram_ce_n, sram_we_n}, 32'h3);
    tick();
    check("coll_sticky", {31'd0, req_err}, 32'd1);

    shift_addr(21'h000010);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    tick();
    snes_mode = 1'b1; snes_addr = 21'h012345;
    #1;
    check("mid_addr", 32'(sram_addr), 32'h10);
    check("mid_oe_n", {31'd0, sram_oe_n}, 32'd0);
    n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    check("mode_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("mode_rd_data", 32'(avr_rdata), 32'hA5);
    tick();
    check("snes_addr", 32'(sram_addr), 32'h012345);
    check("snes_pads", {28'd0, sram_oe_n, sram_we_n, sram_ce_n, sram_data_oe}, 32'h4);
    check("snes_data", 32'(snes_data), 32'h3C);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("snes_drop", {31'd0, busy}, 32'd0);
    snes_mode = 1'b0; tick();

`ifdef SRAM_BRIDGE_AUTOINC_EN
    exp_auto = 21'h000103;
    exp_lock = 21'h000201;
`else
    exp_auto = 21'h000100;
    exp_lock = 21'h000200;
`endif
    shift_addr(21'h000100);
    for (int r = 0; r < 3; r++) begin
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      wait_idle();
    end
    check("autoinc", 32'(addr_q), 32'(exp_auto));

    // Shift and counter strobes held low throughout an access must not move the address.
    shift_addr(21'h000200);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    counter_n = 1'b0; sreg_en_n = 1'b0; sreg_si = 1'b1;
    wait_idle();
    counter_n = 1'b1; sreg_en_n = 1'b1; sreg_si = 1'b0;
    check("busy_lockout", 32'(addr_q), 32'(exp_lock));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
